// File: rtl/pmem_arbiter_if.sv
// Bundle of I-cache, D-cache and physical-memory signals shared by pmem_arbiter.
// The slave modport is the arbiter's view; the master modport is the view of the caches and memory around it.
interface pmem_arbiter_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int LINE_WIDTH = 128
);
   logic                  icache_pmem_read;
   logic [ADDR_WIDTH-1:0] icache_pmem_address;
   logic [LINE_WIDTH-1:0] icache_pmem_rdata;
   logic                  icache_pmem_resp;

   logic                  dcache_pmem_read;
   logic                  dcache_pmem_write;
   logic [ADDR_WIDTH-1:0] dcache_pmem_address;
   logic [LINE_WIDTH-1:0] dcache_pmem_wdata;
   logic [LINE_WIDTH-1:0] dcache_pmem_rdata;
   logic                  dcache_pmem_resp;

   logic                  pmem_read;
   logic                  pmem_write;
   logic [ADDR_WIDTH-1:0] pmem_address;
   logic [LINE_WIDTH-1:0] pmem_wdata;
   logic [LINE_WIDTH-1:0] pmem_rdata;
   logic                  pmem_resp;

   modport slave (
      input  icache_pmem_read, icache_pmem_address,
      output icache_pmem_rdata, icache_pmem_resp,
      input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
      output dcache_pmem_rdata, dcache_pmem_resp,
      output pmem_read, pmem_write, pmem_address, pmem_wdata,
      input  pmem_rdata, pmem_resp
   );

   modport master (
      output icache_pmem_read, icache_pmem_address,
      input  icache_pmem_rdata, icache_pmem_resp,
      output dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
      input  dcache_pmem_rdata, dcache_pmem_resp,
      input  pmem_read, pmem_write, pmem_address, pmem_wdata,
      output pmem_rdata, pmem_resp
   );
endinterface

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between the I-cache fill path
// and the D-cache fill/writeback path; one transaction in flight, registered pmem request.
module pmem_arbiter #(
   parameter int ADDR_WIDTH = 16,
   parameter int LINE_WIDTH = 128
) (
   input  logic              clk,
   input  logic              rst,
   pmem_arbiter_if.slave     bus,
   output logic              busy
);
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] SERVE_I = 2'd1;
   localparam logic [1:0] SERVE_D = 2'd2;
   localparam logic [1:0] RECOVER = 2'd3;

   localparam logic GRANT_I = 1'b0;
   localparam logic GRANT_D = 1'b1;

   logic [1:0]            state_r;
   logic                  last_grant_r;
   logic                  pmem_read_r;
   logic                  pmem_write_r;
   logic [ADDR_WIDTH-1:0] pmem_address_r;
   logic [LINE_WIDTH-1:0] pmem_wdata_r;

   logic                  i_req_s;
   logic                  d_req_s;
   logic                  pick_d_s;
   logic                  icache_resp_s;
   logic                  dcache_resp_s;

   // Request decode and tie-break: on a tie the requester not granted last time wins.
   always_comb begin
      i_req_s = bus.icache_pmem_read;
      d_req_s = bus.dcache_pmem_read | bus.dcache_pmem_write;
      if (i_req_s && d_req_s) begin
         pick_d_s = (last_grant_r == GRANT_I);
      end else if (d_req_s) begin
         pick_d_s = 1'b1;
      end else begin
         pick_d_s = 1'b0;
      end
   end

   // State machine and registered pmem request; the request is frozen while a grant is open.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r        <= IDLE;
         last_grant_r   <= GRANT_D;
         pmem_read_r    <= 1'b0;
         pmem_write_r   <= 1'b0;
         pmem_address_r <= {ADDR_WIDTH{1'b0}};
         pmem_wdata_r   <= {LINE_WIDTH{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (i_req_s || d_req_s) begin
                  if (pick_d_s) begin
                     // A write wins over an (illegal) simultaneous read so the strobes stay exclusive.
                     state_r        <= SERVE_D;
                     last_grant_r   <= GRANT_D;
                     pmem_write_r   <= bus.dcache_pmem_write;
                     pmem_read_r    <= bus.dcache_pmem_read & ~bus.dcache_pmem_write;
                     pmem_address_r <= bus.dcache_pmem_address;
                     pmem_wdata_r   <= bus.dcache_pmem_wdata;
                  end else begin
                     state_r        <= SERVE_I;
                     last_grant_r   <= GRANT_I;
                     pmem_write_r   <= 1'b0;
                     pmem_read_r    <= 1'b1;
                     pmem_address_r <= bus.icache_pmem_address;
                     pmem_wdata_r   <= {LINE_WIDTH{1'b0}};
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            SERVE_I, SERVE_D: begin
               if (bus.pmem_resp) begin
                  state_r      <= RECOVER;
                  pmem_read_r  <= 1'b0;
                  pmem_write_r <= 1'b0;
               end else begin
                  state_r <= state_r;
               end
            end
            RECOVER: begin
               // Owner still sees its own request high here; give it a cycle to drop it.
               state_r <= IDLE;
            end
            default: begin
               state_r      <= IDLE;
               pmem_read_r  <= 1'b0;
               pmem_write_r <= 1'b0;
            end
         endcase
      end
   end

   // Response steering: only the current owner sees pmem_resp.
   always_comb begin
      icache_resp_s = 1'b0;
      dcache_resp_s = 1'b0;
      case (state_r)
         SERVE_I: icache_resp_s = bus.pmem_resp;
         SERVE_D: dcache_resp_s = bus.pmem_resp;
         default: begin
            icache_resp_s = 1'b0;
            dcache_resp_s = 1'b0;
         end
      endcase
   end

   assign bus.icache_pmem_resp  = icache_resp_s;
   assign bus.dcache_pmem_resp  = dcache_resp_s;
   assign bus.icache_pmem_rdata = bus.pmem_rdata;
   assign bus.dcache_pmem_rdata = bus.pmem_rdata;
   assign bus.pmem_read         = pmem_read_r;
   assign bus.pmem_write        = pmem_write_r;
   assign bus.pmem_address      = pmem_address_r;
   assign bus.pmem_wdata        = pmem_wdata_r;
   assign busy                  = (state_r != IDLE);

   pmem_arbiter_checker u_checker (
      .clk         (clk),
      .rst         (rst),
      .pmem_read   (pmem_read_r),
      .pmem_write  (pmem_write_r),
      .icache_resp (icache_resp_s),
      .dcache_resp (dcache_resp_s),
      .busy        (busy)
   );
endmodule

// Protocol invariants of the arbiter outputs.
module pmem_arbiter_checker (
   input logic clk,
   input logic rst,
   input logic pmem_read,
   input logic pmem_write,
   input logic icache_resp,
   input logic dcache_resp,
   input logic busy
);
   // Invariants sampled on every rising edge outside reset.
   always @(posedge clk) begin
      if (!rst) begin
         assert (!(pmem_read && pmem_write))
            else $error("pmem strobes both high");
         assert (!(icache_resp && dcache_resp))
            else $error("both cache responses high");
         assert (busy || (!pmem_read && !pmem_write))
            else $error("strobe high while idle");
      end
   end
endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed self-checking bench for pmem_arbiter: one task per scenario.
module tb_pmem_arbiter;
   logic clk;
   logic rst;
   logic busy;
   int   total;
   int   bad;

   localparam logic [127:0] RD_A5 = {16{8'hA5}};
   localparam logic [127:0] WB    = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

   pmem_arbiter_if #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) bus ();

   pmem_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_strobe(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (bus.pmem_read || bus.pmem_write) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.icache_pmem_read = 1'b0; bus.icache_pmem_address = 16'h0000;
      bus.dcache_pmem_read = 1'b0; bus.dcache_pmem_write = 1'b0;
      bus.dcache_pmem_address = 16'h0000; bus.dcache_pmem_wdata = 128'h0;
      bus.pmem_rdata = 128'h0; bus.pmem_resp = 1'b0;
      tick(); tick();
      total++; if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin bad++; $display("FAIL reset_strobes got r=%b w=%b want 0 0", bus.pmem_read, bus.pmem_write); end
      total++; if (bus.pmem_address !== 16'h0000 || bus.pmem_wdata !== 128'h0) begin bad++; $display("FAIL reset_bus got a=%h d=%h want 0", bus.pmem_address, bus.pmem_wdata); end
      total++; if (busy !== 1'b0 || bus.icache_pmem_resp !== 1'b0 || bus.dcache_pmem_resp !== 1'b0) begin bad++; $display("FAIL reset_busy_resp got busy=%b ir=%b dr=%b want 0", busy, bus.icache_pmem_resp, bus.dcache_pmem_resp); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_ifill();
      bus.icache_pmem_read = 1'b1; bus.icache_pmem_address = 16'h1230;   // cycle 0
      tick();                                                            // cycle 1
      total++; if (bus.pmem_read !== 1'b1 || bus.pmem_write !== 1'b0 || bus.pmem_address !== 16'h1230) begin bad++; $display("FAIL ifill_strobe got r=%b w=%b a=%h want 1 0 1230", bus.pmem_read, bus.pmem_write, bus.pmem_address); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL ifill_busy1 got %b want 1", busy); end
      tick(); tick(); tick(); tick();                                    // cycle 5
      bus.pmem_rdata = RD_A5; bus.pmem_resp = 1'b1;
      #1;
      total++; if (bus.icache_pmem_resp !== 1'b1 || bus.dcache_pmem_resp !== 1'b0) begin bad++; $display("FAIL ifill_resp got ir=%b dr=%b want 1 0", bus.icache_pmem_resp, bus.dcache_pmem_resp); end
      total++; if (bus.icache_pmem_rdata !== RD_A5) begin bad++; $display("FAIL ifill_rdata got %h want %h", bus.icache_pmem_rdata, RD_A5); end
      tick();                                                            // cycle 6
      bus.pmem_resp = 1'b0; bus.icache_pmem_read = 1'b0;
      #1;
      total++; if (busy !== 1'b1 || bus.pmem_read !== 1'b0 || bus.icache_pmem_resp !== 1'b0) begin bad++; $display("FAIL ifill_recover got busy=%b r=%b ir=%b want 1 0 0", busy, bus.pmem_read, bus.icache_pmem_resp); end
      tick();                                                            // cycle 7
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL ifill_idle got busy=%b want 0", busy); end
   endtask

   task automatic test_simultaneous();
      rst = 1'b1; tick(); rst = 1'b0; tick();
      bus.icache_pmem_read = 1'b1; bus.icache_pmem_address = 16'h0040;
      bus.dcache_pmem_read = 1'b1; bus.dcache_pmem_address = 16'h8000;
      tick();
      total++; if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 16'h0040) begin bad++; $display("FAIL sim_first got r=%b a=%h want 1 0040", bus.pmem_read, bus.pmem_address); end
      tick();
      bus.pmem_resp = 1'b1; bus.pmem_rdata = 128'h1111; #1;
      total++; if (bus.icache_pmem_resp !== 1'b1 || bus.dcache_pmem_resp !== 1'b0) begin bad++; $display("FAIL sim_resp_i got ir=%b dr=%b want 1 0", bus.icache_pmem_resp, bus.dcache_pmem_resp); end
      tick(); bus.pmem_resp = 1'b0; bus.icache_pmem_read = 1'b0;         // RECOVER
      tick();                                                            // IDLE
      total++; if (bus.pmem_read !== 1'b0) begin bad++; $display("FAIL sim_gap got r=%b want 0", bus.pmem_read); end
      tick();
      total++; if (bus.pmem_read !== 1'b1 || bus.pmem_write !== 1'b0 || bus.pmem_address !== 16'h8000) begin bad++; $display("FAIL sim_second got r=%b w=%b a=%h want 1 0 8000", bus.pmem_read, bus.pmem_write, bus.pmem_address); end
      bus.pmem_resp = 1'b1; #1;
      total++; if (bus.dcache_pmem_resp !== 1'b1 || bus.icache_pmem_resp !== 1'b0) begin bad++; $display("FAIL sim_resp_d got dr=%b ir=%b want 1 0", bus.dcache_pmem_resp, bus.icache_pmem_resp); end
      tick(); bus.pmem_resp = 1'b0; bus.dcache_pmem_read = 1'b0;
      tick();
   endtask

   task automatic test_round_robin();
      logic [15:0]  exp_addr [4] = '{16'h0100, 16'h9000, 16'h0100, 16'h9000};
      logic         exp_d    [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [127:0] data;
      bit           ok;
      bus.icache_pmem_read = 1'b1; bus.icache_pmem_address = 16'h0100;
      bus.dcache_pmem_read = 1'b1; bus.dcache_pmem_address = 16'h9000;
      for (int t = 0; t < 4; t++) begin
         wait_strobe(ok);
         total++; if (!ok) begin bad++; $display("FAIL rr_timeout txn=%0d got no strobe want strobe", t); end
         total++; if (bus.pmem_address !== exp_addr[t]) begin bad++; $display("FAIL rr_order txn=%0d got a=%h want %h", t, bus.pmem_address, exp_addr[t]); end
         tick();
         data = {96'h0, 32'hC0DE_0000 + 32'(t)};
         bus.pmem_rdata = data; bus.pmem_resp = 1'b1; #1;
         total++; if (bus.dcache_pmem_resp !== exp_d[t] || bus.icache_pmem_resp !== !exp_d[t]) begin bad++; $display("FAIL rr_route txn=%0d got ir=%b dr=%b want dr=%b", t, bus.icache_pmem_resp, bus.dcache_pmem_resp, exp_d[t]); end
         total++; if (bus.dcache_pmem_rdata !== data) begin bad++; $display("FAIL rr_rdata txn=%0d got %h want %h", t, bus.dcache_pmem_rdata, data); end
         tick();
         bus.pmem_resp = 1'b0;
         if (t == 3) begin
            bus.icache_pmem_read = 1'b0; bus.dcache_pmem_read = 1'b0;
         end
      end
      tick(); tick();
   endtask

   task automatic test_writeback();
      bus.dcache_pmem_write = 1'b1; bus.dcache_pmem_address = 16'h2220; bus.dcache_pmem_wdata = WB;
      tick();
      total++; if (bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0 || bus.pmem_address !== 16'h2220) begin bad++; $display("FAIL wb_strobe got w=%b r=%b a=%h want 1 0 2220", bus.pmem_write, bus.pmem_read, bus.pmem_address); end
      total++; if (bus.pmem_wdata !== WB) begin bad++; $display("FAIL wb_wdata got %h want %h", bus.pmem_wdata, WB); end
      bus.dcache_pmem_wdata = ~WB; bus.dcache_pmem_address = 16'h7770;
      tick();
      total++; if (bus.pmem_wdata !== WB || bus.pmem_address !== 16'h2220) begin bad++; $display("FAIL wb_hold got d=%h a=%h want %h 2220", bus.pmem_wdata, bus.pmem_address, WB); end
      bus.pmem_resp = 1'b1; #1;
      total++; if (bus.dcache_pmem_resp !== 1'b1 || bus.icache_pmem_resp !== 1'b0) begin bad++; $display("FAIL wb_resp got dr=%b ir=%b want 1 0", bus.dcache_pmem_resp, bus.icache_pmem_resp); end
      tick(); bus.pmem_resp = 1'b0; bus.dcache_pmem_write = 1'b0;
      tick(); tick();
   endtask

   task automatic test_async_reset();
      bus.dcache_pmem_read = 1'b1; bus.dcache_pmem_address = 16'h3330;
      tick();
      total++; if (busy !== 1'b1 || bus.pmem_read !== 1'b1) begin bad++; $display("FAIL ar_serve got busy=%b r=%b want 1 1", busy, bus.pmem_read); end
      #2 rst = 1'b1;
      #1;
      total++; if (busy !== 1'b0 || bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin bad++; $display("FAIL ar_drop got busy=%b r=%b w=%b want 0 0 0", busy, bus.pmem_read, bus.pmem_write); end
      bus.dcache_pmem_read = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      bus.pmem_resp = 1'b1; #1;
      total++; if (bus.dcache_pmem_resp !== 1'b0 || bus.icache_pmem_resp !== 1'b0) begin bad++; $display("FAIL ar_late_resp got dr=%b ir=%b want 0 0", bus.dcache_pmem_resp, bus.icache_pmem_resp); end
      tick(); bus.pmem_resp = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL ar_idle got busy=%b want 0", busy); end
   endtask

   task automatic test_illegal_and_stray();
      bus.dcache_pmem_read = 1'b1; bus.dcache_pmem_write = 1'b1;
      bus.dcache_pmem_address = 16'h4440; bus.dcache_pmem_wdata = 128'hBEEF;
      tick();
      total++; if (bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0) begin bad++; $display("FAIL illegal_rw got w=%b r=%b want 1 0", bus.pmem_write, bus.pmem_read); end
      bus.pmem_resp = 1'b1;
      tick(); bus.pmem_resp = 1'b0; bus.dcache_pmem_read = 1'b0; bus.dcache_pmem_write = 1'b0;
      tick(); tick();
      bus.pmem_resp = 1'b1; #1;
      total++; if (bus.icache_pmem_resp !== 1'b0 || bus.dcache_pmem_resp !== 1'b0) begin bad++; $display("FAIL stray_resp got ir=%b dr=%b want 0 0", bus.icache_pmem_resp, bus.dcache_pmem_resp); end
      tick(); bus.pmem_resp = 1'b0;
      total++; if (busy !== 1'b0 || bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin bad++; $display("FAIL stray_state got busy=%b r=%b w=%b want 0 0 0", busy, bus.pmem_read, bus.pmem_write); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_single_ifill();
      test_simultaneous();
      test_round_robin();
      test_writeback();
      test_async_reset();
      test_illegal_and_stray();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
